// File: rtl/id_ex_pipeline_reg.sv
// ID->EX pipeline register with hazard stall/flush and a per-entry valid bit.
// Define ID_EX_PERF_CNT_EN to add saturating bubble/stall performance counters.
module id_ex_pipeline_reg #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            validD,
   input  logic            RegWriteD,
   input  logic            MemWriteD,
   input  logic [1:0]      ResultSrcD,
   input  logic            BranchD,
   input  logic            JumpD,
   input  logic            ALUSrcD,
   input  logic [2:0]      ALUControlD,
   input  logic [XLEN-1:0] RD1D,
   input  logic [XLEN-1:0] RD2D,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic [XLEN-1:0] ImmExtD,
   input  logic [4:0]      Rs1D,
   input  logic [4:0]      Rs2D,
   input  logic [4:0]      RdD,
   output logic            validE,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic [1:0]      ResultSrcE,
   output logic            BranchE,
   output logic            JumpE,
   output logic            ALUSrcE,
   output logic [2:0]      ALUControlE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic            mem_write;
      logic [1:0]      result_src;
      logic            branch;
      logic            jump;
      logic            alu_src;
      logic [2:0]      alu_control;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] imm_ext;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
   } stage_t;

   stage_t stage_d, stage_q;

   if (XLEN < 1 || CNT_W < 1) begin : g_param_check
      $error("id_ex_pipeline_reg: XLEN and CNT_W must be positive");
   end

   // NOTE: stage_d gets a full default first, so no path through this block can infer a latch.
   always_comb begin
      stage_d = stage_q;
      if (flush) begin
         stage_d = '0;
      end else if (!stall) begin
         stage_d.valid    = validD;
         stage_d.rd1      = RD1D;
         stage_d.rd2      = RD2D;
         stage_d.pc       = PCD;
         stage_d.pc_plus4 = PCPlus4D;
         stage_d.imm_ext  = ImmExtD;
         stage_d.rs1      = Rs1D;
         stage_d.rs2      = Rs2D;
         stage_d.rd       = RdD;
         // A bubble must never write state or redirect the PC, so its controls are zeroed.
         stage_d.reg_write   = validD & RegWriteD;
         stage_d.mem_write   = validD & MemWriteD;
         stage_d.result_src  = validD ? ResultSrcD : 2'b00;
         stage_d.branch      = validD & BranchD;
         stage_d.jump        = validD & JumpD;
         stage_d.alu_src     = validD & ALUSrcD;
         stage_d.alu_control = validD ? ALUControlD : 3'b000;
      end
   end

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) stage_q <= '0;
      else     stage_q <= stage_d;
   end

   assign validE      = stage_q.valid;
   assign RegWriteE   = stage_q.reg_write;
   assign MemWriteE   = stage_q.mem_write;
   assign ResultSrcE  = stage_q.result_src;
   assign BranchE     = stage_q.branch;
   assign JumpE       = stage_q.jump;
   assign ALUSrcE     = stage_q.alu_src;
   assign ALUControlE = stage_q.alu_control;
   assign RD1E        = stage_q.rd1;
   assign RD2E        = stage_q.rd2;
   assign PCE         = stage_q.pc;
   assign PCPlus4E    = stage_q.pc_plus4;
   assign ImmExtE     = stage_q.imm_ext;
   assign Rs1E        = stage_q.rs1;
   assign Rs2E        = stage_q.rs2;
   assign RdE         = stage_q.rd;

`ifdef ID_EX_PERF_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   logic             bubble_evt, stall_evt;

   assign bubble_evt = flush | (~stall & ~validD);
   assign stall_evt  = stall & ~flush;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      if (bubble_evt && bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      if (stall_evt && stall_cnt_q != '1)   stall_cnt_d  = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
   assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: a reference model pushes the expected
// E-side image per edge into a scoreboard; each test pops and compares after the edge.
module tb_id_ex_pipeline_reg;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_write;
      logic [1:0]  result_src;
      logic        branch;
      logic        jump;
      logic        alu_src;
      logic [2:0]  alu_control;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] imm_ext;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } ex_t;

   typedef struct packed {
      ex_t              e;
      logic [CNT_W-1:0] bub;
      logic [CNT_W-1:0] stl;
   } exp_t;

   logic clk = 1'b0;
   logic rst, stall, flush;
   ex_t  din;
   ex_t  dout;
   logic [CNT_W-1:0] bubble_cnt_o, stall_cnt_o;

   ex_t              m_e;
   logic [CNT_W-1:0] m_bub, m_stl;
   exp_t             exp_q[$];
   exp_t             obs, exp_v;
   int               n_checks = 0;
   int               n_pass   = 0;

   always #5 clk = ~clk;

   id_ex_pipeline_reg #(.XLEN(32), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .validD(din.valid), .RegWriteD(din.reg_write), .MemWriteD(din.mem_write),
      .ResultSrcD(din.result_src), .BranchD(din.branch), .JumpD(din.jump),
      .ALUSrcD(din.alu_src), .ALUControlD(din.alu_control),
      .RD1D(din.rd1), .RD2D(din.rd2), .PCD(din.pc), .PCPlus4D(din.pc_plus4),
      .ImmExtD(din.imm_ext), .Rs1D(din.rs1), .Rs2D(din.rs2), .RdD(din.rd),
      .validE(dout.valid), .RegWriteE(dout.reg_write), .MemWriteE(dout.mem_write),
      .ResultSrcE(dout.result_src), .BranchE(dout.branch), .JumpE(dout.jump),
      .ALUSrcE(dout.alu_src), .ALUControlE(dout.alu_control),
      .RD1E(dout.rd1), .RD2E(dout.rd2), .PCE(dout.pc), .PCPlus4E(dout.pc_plus4),
      .ImmExtE(dout.imm_ext), .Rs1E(dout.rs1), .Rs2E(dout.rs2), .RdE(dout.rd)
`ifdef ID_EX_PERF_CNT_EN
      , .bubble_cnt(bubble_cnt_o), .stall_cnt(stall_cnt_o)
`endif
   );

`ifndef ID_EX_PERF_CNT_EN
   assign bubble_cnt_o = '0;
   assign stall_cnt_o  = '0;
`endif

   function automatic ex_t rand_ex();
      ex_t r;
      r = ex_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      return r;
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o.e   = dout;
      o.bub = bubble_cnt_o;
      o.stl = stall_cnt_o;
      return o;
   endfunction

   // Reference model: advance one edge using current inputs, push expectation, clock.
   task automatic drive_edge();
      exp_t x;
      if (rst) begin
         m_e = '0; m_bub = '0; m_stl = '0;
      end else if (flush) begin
         m_e = '0;
`ifdef ID_EX_PERF_CNT_EN
         if (m_bub != 4'hF) m_bub = m_bub + 4'd1;
`endif
      end else if (stall) begin
`ifdef ID_EX_PERF_CNT_EN
         if (m_stl != 4'hF) m_stl = m_stl + 4'd1;
`endif
      end else if (din.valid) begin
         m_e = din;
      end else begin
         m_e = '0;
         m_e.rd1 = din.rd1; m_e.rd2 = din.rd2; m_e.pc = din.pc;
         m_e.pc_plus4 = din.pc_plus4; m_e.imm_ext = din.imm_ext;
         m_e.rs1 = din.rs1; m_e.rs2 = din.rs2; m_e.rd = din.rd;
`ifdef ID_EX_PERF_CNT_EN
         if (m_bub != 4'hF) m_bub = m_bub + 4'd1;
`endif
      end
      x.e = m_e; x.bub = m_bub; x.stl = m_stl;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b1; flush = 1'b1; din = '1;
      drive_edge();
      obs = observe(); exp_v = exp_q.pop_front(); n_checks++;
      if (obs !== exp_v) $display("FAIL reset_all_zero: got %h expected %h", obs, exp_v);
      else n_pass++;
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_load();
      din = '0; din.valid = 1'b1; din.reg_write = 1'b1; din.rd1 = 32'h1234; din.rd = 5'd5;
      drive_edge();
      obs = observe(); exp_v = exp_q.pop_front(); n_checks++;
      if (obs !== exp_v) $display("FAIL load_image: got %h expected %h", obs, exp_v);
      else n_pass++;
      n_checks++;
      if ({dout.valid, dout.reg_write, dout.rd1, dout.rd} !== {1'b1, 1'b1, 32'h1234, 5'd5})
         $display("FAIL load_fields: got v=%b rw=%b rd1=%h rd=%0d expected v=1 rw=1 rd1=1234 rd=5",
                  dout.valid, dout.reg_write, dout.rd1, dout.rd);
      else n_pass++;
   endtask

   task automatic test_stall();
      ex_t              held;
      logic [CNT_W-1:0] stl0;
      held = dout;
      stl0 = stall_cnt_o;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = rand_ex();
         drive_edge();
         obs = observe(); exp_v = exp_q.pop_front(); n_checks++;
         if (obs !== exp_v) $display("FAIL stall_cycle%0d: got %h expected %h", i, obs, exp_v);
         else n_pass++;
         n_checks++;
         if (dout !== held) $display("FAIL stall_hold%0d: got %h expected %h", i, dout, held);
         else n_pass++;
      end
      stall = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
      n_checks++;
      if (stall_cnt_o !== stl0 + 4'd3)
         $display("FAIL stall_cnt_plus3: got %0d expected %0d", stall_cnt_o, stl0 + 4'd3);
      else n_pass++;
`endif
   endtask

   task automatic test_stall_flush();
      logic [CNT_W-1:0] bub0, stl0;
      bub0 = bubble_cnt_o; stl0 = stall_cnt_o;
      din = rand_ex(); din.valid = 1'b1; din.mem_write = 1'b1;
      stall = 1'b1; flush = 1'b1;
      drive_edge();
      stall = 1'b0; flush = 1'b0;
      obs = observe(); exp_v = exp_q.pop_front(); n_checks++;
      if (obs !== exp_v) $display("FAIL stall_flush: got %h expected %h", obs, exp_v);
      else n_pass++;
      n_checks++;
      if (dout !== ex_t'('0)) $display("FAIL flush_zero: got %h expected 0", dout);
      else n_pass++;
`ifdef ID_EX_PERF_CNT_EN
      n_checks++;
      if ({bubble_cnt_o, stall_cnt_o} !== {bub0 + 4'd1, stl0})
         $display("FAIL flush_counters: got bub=%0d stl=%0d expected bub=%0d stl=%0d",
                  bubble_cnt_o, stall_cnt_o, bub0 + 4'd1, stl0);
      else n_pass++;
`endif
   endtask

   task automatic test_invalid_load();
      logic [CNT_W-1:0] bub0;
      bub0 = bubble_cnt_o;
      din = rand_ex(); din.valid = 1'b0; din.jump = 1'b1; din.imm_ext = 32'h40;
      drive_edge();
      obs = observe(); exp_v = exp_q.pop_front(); n_checks++;
      if (obs !== exp_v) $display("FAIL invalid_load: got %h expected %h", obs, exp_v);
      else n_pass++;
      n_checks++;
      if ({dout.valid, dout.jump, dout.imm_ext} !== {1'b0, 1'b0, 32'h40})
         $display("FAIL invalid_fields: got v=%b j=%b imm=%h expected v=0 j=0 imm=40",
                  dout.valid, dout.jump, dout.imm_ext);
      else n_pass++;
`ifdef ID_EX_PERF_CNT_EN
      n_checks++;
      if (bubble_cnt_o !== bub0 + 4'd1)
         $display("FAIL invalid_bubble_cnt: got %0d expected %0d", bubble_cnt_o, bub0 + 4'd1);
      else n_pass++;
`endif
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         din   = rand_ex();
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 6) == 0);
         rst   = ($urandom_range(0, 19) == 0);
         drive_edge();
         obs = observe(); exp_v = exp_q.pop_front(); n_checks++;
         if (obs !== exp_v) $display("FAIL b2b_cycle%0d: got %h expected %h", i, obs, exp_v);
         else n_pass++;
         n_checks++;
         if (!dout.valid && (dout.reg_write || dout.mem_write || dout.branch || dout.jump))
            $display("FAIL b2b_invariant%0d: got rw=%b mw=%b br=%b j=%b expected all 0",
                     i, dout.reg_write, dout.mem_write, dout.branch, dout.jump);
         else n_pass++;
      end
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_saturation();
      rst = 1'b1; drive_edge(); void'(exp_q.pop_front()); rst = 1'b0;
      flush = 1'b1;
      for (int i = 0; i < 20; i++) begin
         din = rand_ex();
         drive_edge();
         obs = observe(); exp_v = exp_q.pop_front(); n_checks++;
         if (obs !== exp_v) $display("FAIL sat_flush%0d: got %h expected %h", i, obs, exp_v);
         else n_pass++;
      end
      flush = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
      n_checks++;
      if (bubble_cnt_o !== 4'hF) $display("FAIL sat_bubble_cnt: got %h expected f", bubble_cnt_o);
      else n_pass++;
`endif
      rst = 1'b1; stall = 1'b1; din = '1;
      drive_edge();
      rst = 1'b0; stall = 1'b0;
      obs = observe(); exp_v = exp_q.pop_front(); n_checks++;
      if (obs !== exp_v) $display("FAIL sat_reset: got %h expected %h", obs, exp_v);
      else n_pass++;
   endtask

   initial begin
      m_e = '0; m_bub = '0; m_stl = '0;
      rst = 1'b1; stall = 1'b0; flush = 1'b0; din = '0;
      @(negedge clk);
      test_reset();
      test_load();
      test_stall();
      test_stall_flush();
      test_invalid_load();
      test_back_to_back();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
